// File: rtl/kl_pkg.sv
// Shared types and constants for the instruction issue queue.
package kl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned IQ_DEPTH = 8;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } iq_entry_t;

  // Smaller of two small slot counts.
  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Fetch-side push, decode-side issue and status signals of the issue queue.
interface issue_queue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 4
);

  logic [1:0]       fetch_valid_in;
  logic [XLEN-1:0]  fetch_pc_in;
  logic [XLEN-1:0]  fetch_instr0_in;
  logic [XLEN-1:0]  fetch_instr1_in;
  logic             fetch_ready_out;

  logic             iss0_valid_out;
  logic             iss1_valid_out;
  logic [XLEN-1:0]  iss0_instr_out;
  logic [XLEN-1:0]  iss1_instr_out;
  logic [XLEN-1:0]  iss0_pc_out;
  logic [XLEN-1:0]  iss1_pc_out;

  logic [1:0]       iss_take_in;
  logic             flush_in;

  logic [CNT_W-1:0] count_out;
  logic [15:0]      stall_cnt_out;

  // Fetch/decode side: drives pushes, takes and flush.
  modport master (
    output fetch_valid_in, fetch_pc_in, fetch_instr0_in, fetch_instr1_in,
    output iss_take_in, flush_in,
    input  fetch_ready_out,
    input  iss0_valid_out, iss1_valid_out, iss0_instr_out, iss1_instr_out,
    input  iss0_pc_out, iss1_pc_out, count_out, stall_cnt_out
  );

  // Queue side.
  modport slave (
    input  fetch_valid_in, fetch_pc_in, fetch_instr0_in, fetch_instr1_in,
    input  iss_take_in, flush_in,
    output fetch_ready_out,
    output iss0_valid_out, iss1_valid_out, iss0_instr_out, iss1_instr_out,
    output iss0_pc_out, iss1_pc_out, count_out, stall_cnt_out
  );

endinterface

// File: rtl/kl_sat_cnt.sv
// Saturating up-counter with enable and synchronous clear.
module kl_sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt_q
);

  // Count up on enable, hold at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Two-wide in-order instruction issue queue: circular buffer between fetch and decode.
module issue_queue #(
  parameter int unsigned DEPTH = kl_pkg::IQ_DEPTH,
  parameter int unsigned XLEN  = kl_pkg::XLEN
) (
  input logic          clk,
  input logic          rst_n,
  issue_queue_if.slave iq
);

  import kl_pkg::iq_entry_t;
  import kl_pkg::NOP_INSTR;
  import kl_pkg::min2;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = kl_pkg::XLEN;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  iq_entry_t     mem_q [DEPTH];

  logic          ready_c;
  logic          push_en;
  logic          push_two;
  logic [1:0]    push_n;
  logic [1:0]    avail;
  logic [1:0]    take_eff;
  iq_entry_t     ent0, ent1;

  // Push acceptance, take clamping and next pointer/occupancy.
  always_comb begin
    ready_c  = 1'b0;
    push_en  = 1'b0;
    push_two = 1'b0;
    push_n   = 2'd0;
    avail    = 2'd0;
    take_eff = 2'd0;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;

    // Ready looks only at registered occupancy so room freed by takes is not credited.
    ready_c  = rst_n && (count_q <= CW'(DEPTH - 2)) && !iq.flush_in;
    push_en  = ready_c && iq.fetch_valid_in[0];
    push_two = push_en && iq.fetch_valid_in[1];
    push_n   = push_two ? 2'd2 : (push_en ? 2'd1 : 2'd0);

    avail    = (count_q >= CW'(2)) ? 2'd2 : 2'(count_q);
    take_eff = min2(iq.iss_take_in, avail);

    if (iq.flush_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(take_eff);
      tail_d  = tail_q + PW'(push_n);
      count_d = count_q + CW'(push_n) - CW'(take_eff);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entries pushed this cycle; slot1 carries the next sequential PC.
  always_comb begin
    ent0.pc    = EW'(iq.fetch_pc_in);
    ent0.instr = EW'(iq.fetch_instr0_in);
    ent1.pc    = EW'(iq.fetch_pc_in + XLEN'(4));
    ent1.instr = EW'(iq.fetch_instr1_in);
  end

  // Entry storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[tail_q] <= ent0;
    end
    if (push_two) begin
      mem_q[tail_q + PW'(1)] <= ent1;
    end
  end

  // Issue ports read straight from storage; invalid slots show a NOP at PC 0.
  always_comb begin
    iq.iss0_valid_out = (count_q >= CW'(1));
    iq.iss1_valid_out = (count_q >= CW'(2));
    iq.iss0_instr_out = XLEN'(NOP_INSTR);
    iq.iss0_pc_out    = '0;
    iq.iss1_instr_out = XLEN'(NOP_INSTR);
    iq.iss1_pc_out    = '0;
    if (iq.iss0_valid_out) begin
      iq.iss0_instr_out = XLEN'(mem_q[head_q].instr);
      iq.iss0_pc_out    = XLEN'(mem_q[head_q].pc);
    end
    if (iq.iss1_valid_out) begin
      iq.iss1_instr_out = XLEN'(mem_q[head_q + PW'(1)].instr);
      iq.iss1_pc_out    = XLEN'(mem_q[head_q + PW'(1)].pc);
    end
  end

  assign iq.fetch_ready_out = ready_c;
  assign iq.count_out       = count_q;

  // Cycles where decode is starved by an empty queue.
  kl_sat_cnt #(.WIDTH(16)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    ((count_q == '0) && !iq.flush_in),
    .clr   (1'b0),
    .cnt_q (iq.stall_cnt_out)
  );

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: model queue tracks pushed entries in program order.
`timescale 1ns/1ps
module tb_issue_queue;

  import kl_pkg::*;

  logic clk;
  logic rst_n;

  issue_queue_if #(.XLEN(32), .CNT_W(4)) iq_if ();

  issue_queue #(.DEPTH(8), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .iq    (iq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stall_m = 0;
  int seq = 0;
  iq_entry_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output against the model.
  task automatic check_state();
    iq_entry_t e0, e1;
    logic v0, v1;
    v0 = (sb.size() >= 1);
    v1 = (sb.size() >= 2);
    e0 = '0;
    e1 = '0;
    if (v0) e0 = sb[0];
    if (v1) e1 = sb[1];
    check("count", 64'(iq_if.count_out), 64'(sb.size()));
    check("iss0_valid", 64'(iq_if.iss0_valid_out), 64'(v0));
    check("iss1_valid", 64'(iq_if.iss1_valid_out), 64'(v1));
    check("iss0_pc", 64'(iq_if.iss0_pc_out), 64'(e0.pc));
    check("iss0_instr", 64'(iq_if.iss0_instr_out), 64'(e0.instr));
    check("iss1_pc", 64'(iq_if.iss1_pc_out), 64'(e1.pc));
    check("iss1_instr", 64'(iq_if.iss1_instr_out), 64'(e1.instr));
    check("stall_cnt", 64'(iq_if.stall_cnt_out), 64'(stall_m));
  endtask

  // One cycle: drive at the falling edge, check, update model, advance to next falling edge.
  task automatic step(input logic [1:0] v, input logic [31:0] pc,
                      input logic [1:0] take, input logic fl);
    logic [31:0] i0, i1;
    bit rdy, was_empty;
    int avail, te;
    iq_entry_t e;
    i0 = 32'hC000_0000 + 32'(seq);
    i1 = i0 + 32'd1;
    seq += 2;
    iq_if.fetch_valid_in  = v;
    iq_if.fetch_pc_in     = pc;
    iq_if.fetch_instr0_in = i0;
    iq_if.fetch_instr1_in = i1;
    iq_if.iss_take_in     = take;
    iq_if.flush_in        = fl;
    #1;
    check_state();
    rdy = (sb.size() <= 6) && !fl;
    check("fetch_ready", 64'(iq_if.fetch_ready_out), 64'(rdy));
    was_empty = (sb.size() == 0);
    if (fl) begin
      sb.delete();
    end else begin
      avail = (sb.size() >= 2) ? 2 : sb.size();
      te = (int'(take) > avail) ? avail : int'(take);
      repeat (te) void'(sb.pop_front());
      if (rdy && v[0]) begin
        e.pc = pc; e.instr = i0; sb.push_back(e);
        if (v[1]) begin
          e.pc = pc + 32'd4; e.instr = i1; sb.push_back(e);
        end
      end
    end
    if (was_empty && !fl && stall_m < 16'hFFFF) stall_m++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    iq_if.fetch_valid_in  = 2'b00;
    iq_if.fetch_pc_in     = '0;
    iq_if.fetch_instr0_in = '0;
    iq_if.fetch_instr1_in = '0;
    iq_if.iss_take_in     = 2'd0;
    iq_if.flush_in        = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_count", 64'(iq_if.count_out), 64'd0);
    check("rst_ready", 64'(iq_if.fetch_ready_out), 64'd0);
    check("rst_iss0_valid", 64'(iq_if.iss0_valid_out), 64'd0);
    check("rst_iss1_valid", 64'(iq_if.iss1_valid_out), 64'd0);
    check("rst_stall", 64'(iq_if.stall_cnt_out), 64'd0);
    rst_n = 1'b1;

    // First push after reset.
    step(2'b11, 32'h100, 2'd0, 1'b0);
    #1;
    check("first_iss0_pc", 64'(iq_if.iss0_pc_out), 64'h100);
    check("first_iss1_pc", 64'(iq_if.iss1_pc_out), 64'h104);
    check("first_count", 64'(iq_if.count_out), 64'd2);

    // Fill to 7, then take 2 while a push is refused.
    step(2'b11, 32'h200, 2'd0, 1'b0);
    step(2'b11, 32'h300, 2'd0, 1'b0);
    step(2'b01, 32'h400, 2'd0, 1'b0);
    #1;
    check("full_ready_low", 64'(iq_if.fetch_ready_out), 64'd0);
    step(2'b11, 32'h500, 2'd2, 1'b0);
    #1;
    check("full_count_after_take", 64'(iq_if.count_out), 64'd5);
    check("full_ready_back", 64'(iq_if.fetch_ready_out), 64'd1);

    // Steady push 2 / take 2 wraps both pointers.
    for (int i = 0; i < 20; i++) begin
      step(2'b11, 32'h1000 + 32'(i * 8), 2'd2, 1'b0);
      check("wrap_count", 64'(iq_if.count_out), 64'd5);
    end

    // Illegal slot pattern pushes nothing.
    step(2'b10, 32'h2000, 2'd0, 1'b0);

    // Drain to 1, then over-take.
    step(2'b00, 32'h0, 2'd2, 1'b0);
    step(2'b00, 32'h0, 2'd2, 1'b0);
    check("drain_count_one", 64'(iq_if.count_out), 64'd1);
    step(2'b00, 32'h0, 2'd2, 1'b0);
    #1;
    check("clamp_count", 64'(iq_if.count_out), 64'd0);
    check("clamp_iss0_valid", 64'(iq_if.iss0_valid_out), 64'd0);
    check("clamp_iss1_valid", 64'(iq_if.iss1_valid_out), 64'd0);

    // Flush at count 5 with simultaneous push and take.
    step(2'b11, 32'h3000, 2'd0, 1'b0);
    step(2'b11, 32'h3100, 2'd0, 1'b0);
    step(2'b01, 32'h3200, 2'd0, 1'b0);
    check("pre_flush_count", 64'(iq_if.count_out), 64'd5);
    step(2'b11, 32'h3300, 2'd2, 1'b1);
    #1;
    check("flush_count", 64'(iq_if.count_out), 64'd0);
    check("flush_iss0_instr", 64'(iq_if.iss0_instr_out), 64'(NOP_INSTR));
    check("flush_iss0_pc", 64'(iq_if.iss0_pc_out), 64'd0);
    step(2'b00, 32'h0, 2'd0, 1'b0);

    // Long empty stretch saturates the starvation counter.
    idle_inputs();
    repeat (70000) @(posedge clk);
    @(negedge clk);
    stall_m = (stall_m + 70000 > 16'hFFFF) ? 16'hFFFF : stall_m + 70000;
    #1;
    check("stall_saturated", 64'(iq_if.stall_cnt_out), 64'hFFFF);
    step(2'b00, 32'h0, 2'd0, 1'b0);

    // Reset in the middle of operation.
    step(2'b11, 32'h4000, 2'd0, 1'b0);
    step(2'b01, 32'h4100, 2'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_count", 64'(iq_if.count_out), 64'd0);
    check("midrst_ready", 64'(iq_if.fetch_ready_out), 64'd0);
    check("midrst_iss0_valid", 64'(iq_if.iss0_valid_out), 64'd0);
    check("midrst_iss1_valid", 64'(iq_if.iss1_valid_out), 64'd0);
    check("midrst_stall", 64'(iq_if.stall_cnt_out), 64'd0);
    sb.delete();
    stall_m = 0;
    rst_n = 1'b1;
    step(2'b11, 32'h5000, 2'd0, 1'b0);
    step(2'b01, 32'h5100, 2'd1, 1'b0);
    step(2'b00, 32'h0, 2'd2, 1'b0);
    step(2'b00, 32'h0, 2'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: entry count, power of two, >= 4.
REQ-002 SHALL have parameter XLEN, default 32: instruction and PC width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-004 SHALL have ports: fetch_valid_in  in  2  per-slot valid (bit1 set only with bit0); fetch_pc_in  in  XLEN  PC of slot0; fetch_instr0_in / fetch_instr1_in  in  XLEN  older / younger instruction; fetch_ready_out  out  1  queue accepts a push.
REQ-005 SHALL have ports: iss0_valid_out / iss1_valid_out  out  1  P0 (oldest) / P1 (next) slot valid; iss0_instr_out / iss1_instr_out  out  XLEN; iss0_pc_out / iss1_pc_out  out  XLEN.
REQ-006 SHALL have ports: iss_take_in  in  2  number of slots consumed by decode this cycle (0..2); flush_in  in  1  branch redirect, discard all entries.
REQ-007 SHALL have ports: count_out  out  $clog2(DEPTH)+1  occupancy; stall_cnt_out  out  16  saturating count of starved-issue cycles.

Function
REQ-008 SHALL store entries {pc, instr} in a circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-009 SHALL assert fetch_ready_out when registered count <= DEPTH-2 and flush_in is low; takes in the same cycle are not credited.
REQ-010 SHALL push on a rising edge when fetch_ready_out && fetch_valid_in[0]: slot0 at tail with pc = fetch_pc_in; if fetch_valid_in[1], slot1 at tail+1 with pc = fetch_pc_in + 4.
REQ-011 SHALL treat fetch_valid_in = 2'b10 as illegal, pushing nothing.
REQ-012 SHALL drive issue outputs combinationally from storage: iss0 = entry[head] valid when count >= 1; iss1 = entry[head+1] valid when count >= 2.
REQ-013 SHALL drive iss*_instr_out = 32'h0000_0000 (NOP) and iss*_pc_out = 0 for any invalid slot.
REQ-014 SHALL clamp the effective take to the number of valid issue slots; the excess is ignored.
REQ-015 SHALL update on each edge: head += take, tail += pushed, count = count + pushed - take; simultaneous push and take are both honoured.
REQ-016 SHALL make a pushed entry visible on issue outputs from the cycle after the push edge, never combinationally.
REQ-017 SHALL on flush_in clear head, tail and count to 0 at the next edge, ignoring any push and take in that cycle; issue outputs go invalid the following cycle.
REQ-018 SHALL increment stall_cnt_out when count == 0 && !flush_in, saturating at 16'hFFFF.
REQ-019 SHALL never overflow: count <= DEPTH in all reachable states.

Reset
REQ-020 SHALL on rst_n low asynchronously clear head, tail, count and stall_cnt_out to 0, deassert fetch_ready_out, and drive all issue valids low; storage contents are not reset.
REQ-021 SHALL assert fetch_ready_out in the first cycle after rst_n rises; a reset mid-operation discards every queued entry.

Structure
REQ-022 SHALL take XLEN, IQ_DEPTH, NOP_INSTR and typedef iq_entry_t {pc, instr} from shared package kl_pkg.
REQ-023 SHALL instantiate sub-module kl_sat_cnt (parameterised-width saturating counter with enable and clear) for stall_cnt_out; all other logic is inline.

Verification
REQ-024 SHALL verify this scenario: after reset, push 2'b11 at pc 0x100 -> next cycle iss0 pc 0x100, iss1 pc 0x104, count 2.
REQ-025 SHALL verify this scenario: fill to count 7 -> fetch_ready_out low; take 2 with a push attempt -> count 5, push rejected, ready high next cycle.
REQ-026 SHALL verify this scenario: 20 cycles of push 2 / take 2 -> head and tail wrap past DEPTH, program order preserved, count constant.
REQ-027 SHALL verify this scenario: count 1 with iss_take_in = 2 -> take clamped to 1, count 0, both valids low.
REQ-028 SHALL verify this scenario: flush_in with a simultaneous push and take at count 5 -> count 0, outputs NOP next cycle, pushed entries absent.
REQ-029 SHALL verify this scenario: empty queue for 70000 cycles -> stall_cnt_out holds 16'hFFFF; rst_n pulse mid-run -> all state 0 immediately.
